// File: rtl/cla_sub_pipelined.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin, evaluated as a + ~b + ~bin.
// One register rank per prefix level, with a global valid/ready stall.
module cla_sub_pipelined #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    localparam int NS  = LOG2W + 1;
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] a_q [NS];
    logic [WIDTH-1:0] a_d [NS];
    logic [WIDTH-1:0] b_q [NS];
    logic [WIDTH-1:0] b_d [NS];
    logic [WIDTH-1:0] g_q [NS];
    logic [WIDTH-1:0] g_d [NS];
    logic [WIDTH-1:0] p_q [NS];
    logic [WIDTH-1:0] p_d [NS];
    logic [NS-1:0]    c0_q, c0_d;
    logic [NS-1:0]    vld_q, vld_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] a_f, b_f, carry, c_in;
    logic             adv;

    assign adv = ~out_valid_q | out_ready;

    // Stage 0 forms per-bit g/p; stage k combines lanes i and i-2^(k-1).
    // Shifted-in zeros leave G untouched below the span; the mask does the same for P.
    always_comb begin
        a_d[0] = a;
        b_d[0] = b;
        g_d[0] = a & ~b;
        p_d[0] = a | ~b;
        c0_d   = {c0_q[NS-2:0], ~bin};
        vld_d  = {vld_q[NS-2:0], in_valid};
        for (int k = 1; k < NS; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            g_d[k] = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k-1))));
            p_d[k] = p_q[k-1] & ((p_q[k-1] << (1 << (k-1)))
                                 | ~({WIDTH{1'b1}} << (1 << (k-1))));
        end
    end

    // Result data only updates for valid slots, so bubbles and reset leave it quiet.
    always_comb begin
        a_f         = a_q[LOG2W];
        b_f         = b_q[LOG2W];
        carry       = g_q[LOG2W] | (p_q[LOG2W] & {WIDTH{c0_q[LOG2W]}});
        c_in        = {carry[WIDTH-2:0], c0_q[LOG2W]};
        out_valid_d = vld_q[LOG2W];
        diff_d      = diff_q;
        bout_d      = bout_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        if (vld_q[LOG2W]) begin
            diff_d = a_f ^ ~b_f ^ c_in;
            bout_d = ~carry[MSB];
            zero_d = (diff_d == '0);
            ovf_d  = (a_f[MSB] ^ b_f[MSB]) & (diff_d[MSB] ^ a_f[MSB]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NS; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                g_q[k] <= g_d[k];
                p_q[k] <= p_d[k];
            end
            c0_q        <= c0_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_sub_pipelined.sv
// Self-checking bench for cla_sub_pipelined: directed vectors, random streaming with a
// stall, bubbles and mid-flight reset, checked against an integer-arithmetic model.
module tb_cla_sub_pipelined;
    localparam int W   = 16;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout, zero, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cla_sub_pipelined #(.WIDTH(W), .LOG2W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    // Returns {ovf, zero, bout, diff} from plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        int           ua, ub, ud, sa, sb, sd;
        logic [W-1:0] d;
        logic         bo, ov;
        ua = int'(ma);
        ub = int'(mb);
        ud = ua - ub - int'(mbin);
        d  = ud[W-1:0];
        bo = (ua < ub + int'(mbin));
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sd = sa - sb - int'(mbin);
        ov = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
        return {ov, (d == '0), bo, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++;
        if ({diff, bout, zero, ovf} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got diff=%h bout=%b zero=%b ovf=%b want all 0", diff, bout, zero, ovf);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{16'h1234, 16'h0000, 16'h0000, 16'hABCD, 16'h8000};
        logic [W-1:0] tb [5] = '{16'h0234, 16'h0001, 16'h0000, 16'hABCD, 16'h0001};
        logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W+2:0] te [5] = '{{3'b000, 16'h1000}, {3'b001, 16'hFFFF}, {3'b001, 16'hFFFF},
                                 {3'b010, 16'h0000}, {3'b100, 16'h7FFF}};
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            a = ta[i]; b = tb[i]; bin = tc[i]; in_valid = 1'b1;
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed%0d_in_ready got %b want 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            for (int k = 1; k <= LAT + 1; k++) begin
                tick();
                n_tests++;
                if (out_valid !== (k == LAT)) begin
                    n_fail++; $display("FAIL directed%0d_latency cycle %0d out_valid got %b want %b", i, k, out_valid, (k == LAT));
                end
                if (k == LAT) begin
                    n_tests++;
                    if ({ovf, zero, bout, diff} !== te[i]) begin
                        n_fail++;
                        $display("FAIL directed%0d_result got ovf=%b zero=%b bout=%b diff=%h want ovf=%b zero=%b bout=%b diff=%h",
                                 i, ovf, zero, bout, diff, te[i][W+2], te[i][W+1], te[i][W], te[i][W-1:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_stream_stall();
        logic [W+2:0] exp_q [$];
        logic [W+2:0] e, held;
        int sent = 0, got = 0, cyc = 0;
        while (got < 20 && cyc < 300) begin
            out_ready = !(cyc >= 10 && cyc < 13);
            if (sent < 20) begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom & 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && out_valid) begin
                n_tests++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d got %b want 0", cyc, in_ready); end
                if (cyc == 10) begin
                    held = {ovf, zero, bout, diff};
                end else begin
                    n_tests++;
                    if ({ovf, zero, bout, diff} !== held) begin
                        n_fail++; $display("FAIL stall_hold cycle %0d got %h want %h", cyc, {ovf, zero, bout, diff}, held);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_spurious cycle %0d got diff=%h want no result", cyc, diff);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, zero, bout, diff} !== e) begin
                        n_fail++;
                        $display("FAIL stream_result%0d got ovf=%b zero=%b bout=%b diff=%h want ovf=%b zero=%b bout=%b diff=%h",
                                 got, ovf, zero, bout, diff, e[W+2], e[W+1], e[W], e[W-1:0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (got != 20) begin n_fail++; $display("FAIL stream_count got %0d results want 20 (cycle budget)", got); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_leftover got %0d pending want 0", exp_q.size()); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_duplicate got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_bubbles();
        logic [3:0]   pat = 4'b0101;
        logic [W+2:0] res [4];
        logic         ev;
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            in_valid = (j < 4) ? pat[j] : 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom & 1);
            if (j < 4) res[j] = model(a, b, bin);
            tick();
            ev = (j >= LAT && j - LAT < 4) ? pat[j-LAT] : 1'b0;
            n_tests++;
            if (out_valid !== ev) begin
                n_fail++; $display("FAIL bubble_valid cycle %0d got %b want %b", j, out_valid, ev);
            end
            if (ev && out_valid) begin
                n_tests++;
                if ({ovf, zero, bout, diff} !== res[j-LAT]) begin
                    n_fail++; $display("FAIL bubble_result cycle %0d got %h want %h", j, {ovf, zero, bout, diff}, res[j-LAT]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [W+2:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom & 1); in_valid = 1'b1;
            rst = (i == 2);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if ({out_valid, diff, bout, zero, ovf} !== '0) begin
                n_fail++;
                $display("FAIL midreset_flush cycle %0d got out_valid=%b diff=%h bout=%b zero=%b ovf=%b want all 0",
                         k, out_valid, diff, bout, zero, ovf);
            end
            tick();
        end
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom & 1); in_valid = 1'b1;
        e = model(a, b, bin);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            n_tests++;
            if (out_valid !== (k == LAT)) begin
                n_fail++; $display("FAIL midreset_latency cycle %0d got out_valid=%b want %b", k, out_valid, (k == LAT));
            end
            if (k == LAT) begin
                n_tests++;
                if ({ovf, zero, bout, diff} !== e) begin
                    n_fail++; $display("FAIL midreset_result got %h want %h", {ovf, zero, bout, diff}, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream_stall();
        test_bubbles();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
